mult_rr_scheduler: RTL and testbench

- Shares one `signed_multiplier` instance among NREQ requesters.
- The multiplier is the 4-bit sign-magnitude core: bit3 is the sign, bits 2:0 the magnitude. Its 7-bit product has o[6] as sign and o[5:0] as magnitude.
- This block performs round-robin arbitration, registers the operands, drives the shared combinational core and holds the tagged result behind a valid/ready response port.
- It sits between the ALU-side requesters and the multiplier.

---
 rtl/mult_rr_scheduler.sv | 163 ++++++++++++++++
 tb/tb_mult_rr_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler: round-robin front end sharing one sign-magnitude
// 4x4 multiplier among NREQ requesters, with a 2-stage valid/ready pipe.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]    requester i has an operand pair
//   req_ready  [NREQ]    one-hot grant (transfer when valid & ready)
//   req_a      [4*NREQ]  packed operand A, lane i at [4i+3:4i]
//   req_b      [4*NREQ]  packed operand B, same packing
//   rsp_valid  result register holds a product
//   rsp_ready  consumer accepts the product
//   rsp_id     [IDW]     requester that owns the product
//   rsp_prod   [7]       sign-magnitude product, sign at [6]

// signed_multiplier: combinational 4-bit sign-magnitude multiply.
// Ports: i_a, i_b (sign at [3]); o_prod (sign at [6], magnitude [5:0]).
module signed_multiplier (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [6:0] o_prod
);
    logic [5:0] w_mag;

    assign w_mag  = {3'b000, i_a[2:0]} * {3'b000, i_b[2:0]};
    assign o_prod = {i_a[3] ^ i_b[3], w_mag};
endmodule

module mult_rr_scheduler #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter bit NORM_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [4*NREQ-1:0] req_a,
    input  logic [4*NREQ-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [6:0]        rsp_prod
);
    // One extra bit so ptr+k can be reduced modulo NREQ without overflow.
    localparam int            PW     = IDW + 1;
    localparam logic [PW-1:0] NREQ_W = PW'(NREQ);

    logic [IDW-1:0] r_ptr;
    logic           r_s1_v;
    logic [3:0]     r_op_a;
    logic [3:0]     r_op_b;
    logic [IDW-1:0] r_op_id;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [6:0]     r_rsp_prod;

    logic           w_s2_free;
    logic           w_s1_adv;
    logic           w_s1_free;
    logic           w_found;
    logic [IDW-1:0] w_gnt_id;
    logic [PW-1:0]  w_idx;
    logic [PW-1:0]  w_ptr_sum;
    logic [IDW-1:0] w_ptr_nxt;
    logic           w_hs;
    logic [3:0]     w_gnt_a;
    logic [3:0]     w_gnt_b;
    logic [6:0]     w_core;
    logic [6:0]     w_prod;

    assign w_s2_free = !r_rsp_valid | rsp_ready;
    assign w_s1_adv  = r_s1_v & w_s2_free;
    assign w_s1_free = !r_s1_v | w_s2_free;

    // Scan from r_ptr upward, wrapping at NREQ; first valid wins.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + PW'(k);
            if (w_idx >= NREQ_W) begin
                w_idx = w_idx - NREQ_W;
            end
            if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[IDW-1:0];
            end
        end
    end

    assign w_hs = w_found & w_s1_free;

    // Grant is masked during reset, when the pipe looks empty.
    always_comb begin
        req_ready = '0;
        if (w_hs && rst_n) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_comb begin
        w_ptr_sum = {1'b0, w_gnt_id} + PW'(1);
        w_ptr_nxt = w_ptr_sum[IDW-1:0];
        if (w_ptr_sum >= NREQ_W) begin
            w_ptr_nxt = '0;
        end
    end

    assign w_gnt_a = req_a[4*w_gnt_id +: 4];
    assign w_gnt_b = req_b[4*w_gnt_id +: 4];

    signed_multiplier u_mul (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .o_prod (w_core)
    );

    // Optionally fold -0 into +0.
    always_comb begin
        w_prod = w_core;
        if (NORM_ZERO && (w_core[5:0] == 6'd0)) begin
            w_prod = 7'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_s1_v  <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_op_id <= '0;
        end else if (w_hs) begin
            r_ptr   <= w_ptr_nxt;
            r_s1_v  <= 1'b1;
            r_op_a  <= w_gnt_a;
            r_op_b  <= w_gnt_b;
            r_op_id <= w_gnt_id;
        end else if (w_s1_adv) begin
            r_s1_v  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_prod  <= '0;
        end else if (w_s1_adv) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_op_id;
            r_rsp_prod  <= w_prod;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_prod  = r_rsp_prod;
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler: directed vectors plus hand-written sequences
// for arbitration order, backpressure, async reset and pointer wrap.
module tb_mult_rr_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [6:0]  rsp_prod;

    logic [3:0]  z_req_ready;
    logic        z_rsp_valid;
    logic [1:0]  z_rsp_id;
    logic [6:0]  z_rsp_prod;

    int checks   = 0;
    int failures = 0;
    int hs_cnt   = 0;

    always #5 clk = ~clk;

    mult_rr_scheduler #(.NREQ(4), .IDW(2), .NORM_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_prod  (rsp_prod)
    );

    mult_rr_scheduler #(.NREQ(4), .IDW(2), .NORM_ZERO(1'b0)) dut_nz0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (z_req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (z_rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (z_rsp_id),
        .rsp_prod  (z_rsp_prod)
    );

    always @(posedge clk) begin
        if (|(req_valid & req_ready)) hs_cnt = hs_cnt + 1;
    end

    typedef struct {
        int         id;
        logic [3:0] a;
        logic [3:0] b;
        logic [6:0] p1;
        logic [6:0] p0;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [3:0] a,
                            input logic [3:0] b);
        req_a[4*i +: 4] = a;
        req_b[4*i +: 4] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int seq[6];
        int base;
        logic [3:0] oh;

        vecs[0] = '{1, 4'b1011, 4'b0010, 7'b1000110, 7'b1000110};
        vecs[1] = '{0, 4'b0111, 4'b1111, 7'b1110001, 7'b1110001};
        vecs[2] = '{2, 4'b1000, 4'b0101, 7'b0000000, 7'b1000000};
        vecs[3] = '{3, 4'b0011, 4'b0011, 7'b0001001, 7'b0001001};
        vecs[4] = '{1, 4'b1101, 4'b1110, 7'b0011110, 7'b0011110};
        vecs[5] = '{0, 4'b0000, 4'b1111, 7'b0000000, 7'b1000000};
        vecs[6] = '{2, 4'b1111, 4'b0001, 7'b1000111, 7'b1000111};
        seq = '{0, 1, 2, 3, 0, 1};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset state, with requests pending during reset.
        #1;
        req_valid = 4'hF;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_prod", 32'(rsp_prod), 32'h0);
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single-transaction vectors.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            set_lane(vecs[v].id, vecs[v].a, vecs[v].b);
            oh = 4'b0001 << vecs[v].id;
            req_valid = oh;
            #1;
            chk("vec_grant", 32'(req_ready), 32'(oh));
            @(negedge clk);
            req_valid = '0;
            #1;
            chk("vec_latency", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            #1;
            chk("vec_valid", 32'(rsp_valid), 32'h1);
            chk("vec_id", 32'(rsp_id), 32'(vecs[v].id));
            chk("vec_prod", 32'(rsp_prod), 32'(vecs[v].p1));
            chk("vec_prod_nz0", 32'(z_rsp_prod), 32'(vecs[v].p0));
        end

        // Round-robin with all requesters held valid.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_lane(i, 4'(i + 1), 4'b0010);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) req_valid = 4'hF;
            if (c == 6) req_valid = '0;
            #1;
            if (c < 6) begin
                chk("rr_grant", 32'(req_ready), 32'(4'b0001 << seq[c]));
            end
            if (c >= 2) begin
                chk("rr_valid", 32'(rsp_valid), 32'h1);
                chk("rr_id", 32'(rsp_id), 32'(seq[c-2]));
                chk("rr_prod", 32'(rsp_prod), 32'(2 * (seq[c-2] + 1)));
            end
        end
        @(negedge clk);
        #1;
        chk("rr_drain", 32'(rsp_valid), 32'h0);

        // Backpressure: requesters 2 and 3, rsp_ready low 5 cycles.
        set_lane(2, 4'b0010, 4'b0011);
        set_lane(3, 4'b1100, 4'b0011);
        for (int d = 0; d < 9; d++) begin
            @(negedge clk);
            if (d == 0) begin
                rsp_ready = 1'b0;
                req_valid = 4'b1100;
                base = hs_cnt;
            end
            if (d == 5) rsp_ready = 1'b1;
            if (d == 6) req_valid = '0;
            #1;
            case (d)
                0: chk("bp_grant0", 32'(req_ready), 32'h4);
                1: chk("bp_grant1", 32'(req_ready), 32'h8);
                2, 3, 4: begin
                    chk("bp_stall_ready", 32'(req_ready), 32'h0);
                    chk("bp_stall_valid", 32'(rsp_valid), 32'h1);
                    chk("bp_stall_id", 32'(rsp_id), 32'h2);
                    chk("bp_stall_prod", 32'(rsp_prod), 32'h06);
                end
                5: begin
                    chk("bp_hs_count", 32'(hs_cnt - base), 32'h2);
                    chk("bp_resume", 32'(req_ready), 32'h4);
                    chk("bp_rel_id", 32'(rsp_id), 32'h2);
                end
                6: begin
                    chk("bp_second_id", 32'(rsp_id), 32'h3);
                    chk("bp_second_prod", 32'(rsp_prod), 32'h4C);
                end
                7: begin
                    chk("bp_third_id", 32'(rsp_id), 32'h2);
                    chk("bp_third_prod", 32'(rsp_prod), 32'h06);
                end
                default: chk("bp_drain", 32'(rsp_valid), 32'h0);
            endcase
        end

        // Async reset with S1 and S2 both full.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b1100;
        repeat (2) @(negedge clk);
        #1;
        chk("ar_full_ready", 32'(req_ready), 32'h0);
        chk("ar_full_valid", 32'(rsp_valid), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(rsp_valid), 32'h0);
        chk("ar_ready", 32'(req_ready), 32'h0);
        chk("ar_prod", 32'(rsp_prod), 32'h0);
        @(negedge clk);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("ar_first_grant", 32'(req_ready), 32'h4);
        chk("ar_no_stale0", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("ar_no_stale1", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("ar_valid_after", 32'(rsp_valid), 32'h1);
        chk("ar_id_after", 32'(rsp_id), 32'h2);
        chk("ar_prod_after", 32'(rsp_prod), 32'h06);

        // Pointer wrap: requester 3 alone, then 0 and 3 together.
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            if (e == 0) req_valid = 4'b1000;
            if (e == 3) req_valid = 4'b1001;
            if (e == 5) req_valid = '0;
            #1;
            if (e < 3) chk("wrap_solo", 32'(req_ready), 32'h8);
            if (e == 3) chk("wrap_to0", 32'(req_ready), 32'h1);
            if (e == 4) chk("wrap_then3", 32'(req_ready), 32'h8);
            if (e == 5) chk("wrap_rsp0", 32'(rsp_id), 32'h0);
            if (e == 6) chk("wrap_rsp3", 32'(rsp_id), 32'h3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
